// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters, with a
// one-entry registered response slot. Define ALU_ARB_FIXED_PRIO_EN for fixed priority.
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_rs1,
  input  logic [NUM_REQ*32-1:0] req_rs2,
  input  logic [NUM_REQ*32-1:0] req_imm,
  input  logic [NUM_REQ*32-1:0] req_pc,
  input  logic [NUM_REQ*6-1:0]  req_instr_id,
  output logic [31:0]           alu_rs1,
  output logic [31:0]           alu_rs2,
  output logic [31:0]           alu_imm,
  output logic [31:0]           alu_pc,
  output logic [5:0]            alu_instr_id,
  input  logic [31:0]           alu_result,
  output logic                  resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_data,
  input  logic                  resp_ready
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] winner;
  logic [PTR_W:0]   cand;
  logic             found;
  logic             slot_free;
  logic             grant;

  // A new result may enter the slot when it is empty or being drained this cycle.
  assign slot_free = !resp_valid || resp_ready;
  assign grant     = found && slot_free && !rst;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!found && req_valid[cand[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready    = '0;
    alu_rs1      = '0;
    alu_rs2      = '0;
    alu_imm      = '0;
    alu_pc       = '0;
    alu_instr_id = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
      alu_rs1           = req_rs1[32*int'(winner) +: 32];
      alu_rs2           = req_rs2[32*int'(winner) +: 32];
      alu_imm           = req_imm[32*int'(winner) +: 32];
      alu_pc            = req_pc[32*int'(winner) +: 32];
      alu_instr_id      = req_instr_id[6*int'(winner) +: 6];
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else if (grant) begin
      resp_valid <= 1'b1;
      resp_id    <= ID_W'(winner);
      resp_data  <= alu_result;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  // The requester just served drops to lowest priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (winner == PTR_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter (NUM_REQ=3): directed test-plan steps, then random traffic
// against a behavioural arbitration model. Honours ALU_ARB_FIXED_PRIO_EN if defined.
module tb_alu_share_arbiter;

  localparam int N    = 3;
  localparam int ID_W = 2;

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_XOR   = 6'd2;
  localparam logic [5:0] OP_ADDI  = 6'd3;
  localparam logic [5:0] OP_SLL   = 6'd4;
  localparam logic [5:0] OP_AUIPC = 6'd5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_rs1, req_rs2, req_imm, req_pc;
  logic [N*6-1:0]  req_instr_id;
  logic [31:0]     alu_rs1, alu_rs2, alu_imm, alu_pc, alu_result;
  logic [5:0]      alu_instr_id;
  logic            resp_valid;
  logic [ID_W-1:0] resp_id;
  logic [31:0]     resp_data;
  logic            resp_ready;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   m_valid = 1'b0;
  int   m_ptr = 0;
  int   w;
  logic [N-1:0] exp_ready;
  logic [N-1:0] rdy;
  logic [N-1:0] exp_rr [4];
  logic [N-1:0] exp_wr [4];

  alu_share_arbiter #(.NUM_REQ(N), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .req_pc(req_pc),
    .req_instr_id(req_instr_id),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm), .alu_pc(alu_pc),
    .alu_instr_id(alu_instr_id), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  // The execute-stage ALU the arbiter is sharing.
  function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [31:0] a, b, imm, pc);
    case (op)
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_XOR:   return a ^ b;
      OP_ADDI:  return a + imm;
      OP_SLL:   return a << b[4:0];
      OP_AUIPC: return pc + imm;
      default:  return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_instr_id, alu_rs1, alu_rs2, alu_imm, alu_pc);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [5:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc);
    req_valid[i]          = v;
    req_instr_id[6*i +: 6] = op;
    req_rs1[32*i +: 32]   = a;
    req_rs2[32*i +: 32]   = b;
    req_imm[32*i +: 32]   = imm;
    req_pc[32*i +: 32]    = pc;
  endtask

  // Reference model: decides who should be granted, pushes expected responses.
  always begin
    @(negedge clk);
    #1;
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    exp_ready = '0;
    if (!rst && w >= 0 && (!m_valid || resp_ready)) exp_ready[w] = 1'b1;
    check("model_req_ready", req_ready, exp_ready);
    if (!rst) check("model_resp_valid", resp_valid, m_valid);
    if (rst) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      sb.delete();
    end else if (exp_ready != '0) begin
      sb.push_back('{id: ID_W'(w),
                     data: alu_fn(req_instr_id[6*w +: 6], req_rs1[32*w +: 32], req_rs2[32*w +: 32],
                                  req_imm[32*w +: 32], req_pc[32*w +: 32])});
      m_valid = 1'b1;
`ifndef ALU_ARB_FIXED_PRIO_EN
      m_ptr = (w + 1) % N;
`endif
    end else if (resp_ready) begin
      m_valid = 1'b0;
    end
  end

  // Monitor: every response handed to the consumer must match the oldest expected one.
  always begin
    @(negedge clk);
    if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL mon_unexpected: got id=%0d data=%0h expected no response", resp_id, resp_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("mon_resp_id", resp_id, e.id);
        check("mon_resp_data", resp_data, e.data);
      end
    end
  end

  initial begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_rr = '{3'b001, 3'b001, 3'b001, 3'b001};
    exp_wr = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
    exp_rr = '{3'b001, 3'b010, 3'b001, 3'b010};
    exp_wr = '{3'b100, 3'b001, 3'b100, 3'b001};
`endif
    rst = 1'b1;
    req_valid = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0; req_pc = '0; req_instr_id = '0;
    resp_ready = 1'b0;

    // Reset: outputs quiet even with requests pending.
    tick();
    set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7, 32'd0, 32'd0);
    set_req(1, 1'b1, OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_alu_rs1", alu_rs1, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_data", resp_data, 0);

    // Single request: ADD 5+7.
    tick();
    rst = 1'b0;
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("single_ready", req_ready, 3'b001);
    check("single_alu_rs1", alu_rs1, 5);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("single_valid", resp_valid, 1);
    check("single_id", resp_id, 0);
    check("single_data", resp_data, 12);

    // Contention from a fresh pointer.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1'b1, OP_SUB, 32'd10, 32'd3, 32'd0, 32'd0);
    set_req(1, 1'b1, OP_XOR, 32'hF0, 32'h0F, 32'd0, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("contention_grant%0d", c), req_ready, exp_rr[c]);
      tick();
    end

    // Backpressure: ADDI 1+(-1) held while requester 1 waits.
    req_valid = '0;
    set_req(0, 1'b1, OP_ADDI, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0);
    tick();
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, OP_ADD, 32'd2, 32'd3, 32'd0, 32'd0);
    resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_req_ready", req_ready, 0);
      check("bp_resp_valid", resp_valid, 1);
      check("bp_resp_data", resp_data, 0);
      tick();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release", req_ready, 3'b010);
    tick();

    // Back-to-back: SLL accepted while the slot drains.
    req_valid[1] = 1'b0;
    set_req(0, 1'b1, OP_SLL, 32'd1, 32'd4, 32'd0, 32'd0);
    @(negedge clk);
    check("b2b_slot_full", resp_valid, 1);
    check("b2b_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    resp_ready = 1'b0;
    @(negedge clk);
    check("b2b_valid", resp_valid, 1);
    check("b2b_id", resp_id, 0);
    check("b2b_data", resp_data, 16);

    // Reset while holding a response with the pointer at 1.
    tick();
    rst = 1'b1;
    resp_ready = 1'b1;
    set_req(0, 1'b1, OP_ADD, 32'd8, 32'd9, 32'd0, 32'd0);
    set_req(1, 1'b1, OP_SUB, 32'd9, 32'd8, 32'd0, 32'd0);
    @(negedge clk);
    check("midrst_req_ready", req_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", resp_valid, 0);
    check("midrst_data", resp_data, 0);
    check("midrst_first_grant", req_ready, 3'b001);
    tick();

    // Three-requester wrap: 2 and 0 valid, 1 idle.
    req_valid[1] = 1'b0;
    set_req(2, 1'b1, OP_AUIPC, 32'd0, 32'd0, 32'h10, 32'h100);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("wrap_grant%0d", c), req_ready, exp_wr[c]);
      tick();
    end

    // Random traffic honouring the hold-until-ready contract.
    req_valid = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      rdy = req_ready;
      tick();
      rst        = ($urandom_range(0, 39) == 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || rdy[i]) begin
          if ($urandom_range(0, 2) != 0)
            set_req(i, 1'b1, 6'($urandom_range(0, 5)), $urandom, $urandom, $urandom, $urandom);
          else
            req_valid[i] = 1'b0;
        end
      end
    end

    rst = 1'b0;
    req_valid = '0;
    resp_ready = 1'b1;
    repeat (3) tick();
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
